node_position_streamer: RTL

//  Reader end of the verlet core's node-position output. On request it snapshots the core's flattened
//  x/y position buses and streams them, one node per beat, over a valid/ready interface toward the

---
 rtl/node_position_streamer_pkg.sv | 19 +
 rtl/node_position_streamer_checksum_acc.sv | 27 ++
 rtl/node_position_streamer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/node_position_streamer_pkg.sv
// Shared definitions for the node position streamer: FSM state encoding,
// output core-id width and the beat-index width helper.
package node_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SNAP   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int CORE_ID_W = 8;

    // Index must be able to hold 0..nodes (the extra value is the checksum beat).
    function automatic int idx_width(input int nodes);
        return (nodes < 1) ? 1 : $clog2(nodes + 1);
    endfunction

endpackage

// File: rtl/node_position_streamer_checksum_acc.sv
// XOR fold of the snapshot x/y position vectors, used for the optional
// trailing checksum beat. Only present when STREAM_CHECKSUM_EN is defined.
`ifdef STREAM_CHECKSUM_EN
module stream_checksum_acc
    import node_stream_pkg::*;
#(
    parameter int node_contains = 5,
    parameter int width         = 32
) (
    input  logic [width*node_contains-1:0] shadow_x,
    input  logic [width*node_contains-1:0] shadow_y,
    output logic [width-1:0]               sum_x,
    output logic [width-1:0]               sum_y
);

    // Bitwise XOR across every node coordinate held in the shadow registers.
    always_comb begin
        sum_x = '0;
        sum_y = '0;
        for (int unsigned i = 0; i < node_contains; i++) begin
            sum_x = sum_x ^ shadow_x[width*i +: width];
            sum_y = sum_y ^ shadow_y[width*i +: width];
        end
    end

endmodule
`endif

// File: rtl/node_position_streamer.sv
// Node position streamer: snapshots the core's flattened x/y position buses on
// request and streams one node per beat over a valid/ready interface.
// Optional feature: define STREAM_CHECKSUM_EN to append an XOR checksum beat
// (index node_contains) that carries out_last instead of the final node beat.
module node_position_streamer
    import node_stream_pkg::*;
#(
    parameter int node_contains = 5,
    parameter int core_id       = 1,
    parameter int width         = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  frame_req,
    input  logic [width*node_contains-1:0]        all_nodes_x_position,
    input  logic [width*node_contains-1:0]        all_nodes_y_position,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [idx_width(node_contains)-1:0]   out_node_idx,
    output logic [width-1:0]                      out_x,
    output logic [width-1:0]                      out_y,
    output logic [CORE_ID_W-1:0]                  out_core_id,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  req_dropped
);

    localparam int IDX_W = idx_width(node_contains);
`ifdef STREAM_CHECKSUM_EN
    localparam int BEATS = node_contains + 1;
`else
    localparam int BEATS = node_contains;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    state_t                         state;
    state_t                         state_next;
    logic [width*node_contains-1:0] shadow_x;
    logic [width*node_contains-1:0] shadow_y;
    logic [IDX_W-1:0]               idx;
    logic                           fire;
    logic                           at_last;
    logic [width-1:0]               beat_x;
    logic [width-1:0]               beat_y;
    logic                           frame_done_q;
    logic                           req_dropped_q;

`ifdef STREAM_CHECKSUM_EN
    logic [width-1:0] sum_x;
    logic [width-1:0] sum_y;

    stream_checksum_acc #(
        .node_contains (node_contains),
        .width         (width)
    ) u_checksum (
        .shadow_x (shadow_x),
        .shadow_y (shadow_y),
        .sum_x    (sum_x),
        .sum_y    (sum_y)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot capture and beat index advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_x <= '0;
            shadow_y <= '0;
            idx      <= '0;
        end else if (state == S_SNAP) begin
            shadow_x <= all_nodes_x_position;
            shadow_y <= all_nodes_y_position;
            idx      <= '0;
        end else if ((state == S_STREAM) && fire) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Registered status pulses: done follows the DONE state by one cycle,
    // dropped flags any request seen while a frame is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_done_q  <= 1'b0;
            req_dropped_q <= 1'b0;
        end else begin
            frame_done_q  <= (state == S_DONE);
            req_dropped_q <= frame_req && (state != S_IDLE);
        end
    end

    // Next-state logic; a frame ends on the accepted last beat.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (frame_req) state_next = S_SNAP;
            S_SNAP:   state_next = S_STREAM;
            S_STREAM: if (fire && at_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Select the current beat's coordinates from the shadow registers.
    always_comb begin
        beat_x = '0;
        beat_y = '0;
        for (int unsigned i = 0; i < node_contains; i++) begin
            if (idx == IDX_W'(i)) begin
                beat_x = shadow_x[width*i +: width];
                beat_y = shadow_y[width*i +: width];
            end
        end
`ifdef STREAM_CHECKSUM_EN
        if (idx == IDX_W'(node_contains)) begin
            beat_x = sum_x;
            beat_y = sum_y;
        end
`endif
    end

    // Beat outputs are driven from registers only, so they hold while stalled.
    assign out_valid    = (state == S_STREAM);
    assign fire         = out_valid && out_ready;
    assign at_last      = (idx == LAST_IDX);
    assign out_last     = out_valid && at_last;
    assign out_node_idx = out_valid ? idx : '0;
    assign out_x        = out_valid ? beat_x : '0;
    assign out_y        = out_valid ? beat_y : '0;
    assign out_core_id  = out_valid ? CORE_ID_W'(core_id) : '0;
    assign busy         = (state != S_IDLE);
    assign frame_done   = frame_done_q;
    assign req_dropped  = req_dropped_q;

endmodule
